cim_fetch_unit: RTL and testbench

- Parametrised continuous-item-memory (CIM) fetch engine; successor to the fixed five-channel CIM lookup.
- Maps a (channel, feature level) request to a ROM address through a runtime-programmable per-channel base/count table and drives an external synchronous ROM.
- Buffers returned hypervectors in an output FIFO behind valid/ready handshakes on both sides.
- Sits between the feature-quantisation front end and the spatial/temporal encoder.

---
 rtl/cim_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_cim_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_fetch_unit.sv
// Continuous-item-memory fetch engine.
// Maps (channel, feature level) to a ROM address through a programmable per-channel
// base/count table, issues the read to an external synchronous ROM, and queues the
// returned hypervectors in an output FIFO. Credits bound outstanding work to FIFO_DEPTH.
// Optional build macro: CIM_CLAMP_EN clamps out-of-range feature levels to count-1.
module cim_fetch_unit #(
  parameter int unsigned HV_DIM       = 2000,
  parameter int unsigned NUM_CHANNELS = 6,
  parameter int unsigned CHAN_W       = 3,
  parameter int unsigned FEAT_W       = 6,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned ROM_LATENCY  = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [FEAT_W-1:0] in_feature,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_cim,
  output logic [CHAN_W-1:0] out_chan,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [HV_DIM-1:0] rom_dout,
  input  logic              cfg_we,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [FEAT_W:0]   cfg_count,
  output logic              err
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned PipeD = ROM_LATENCY + 1;

  logic [ADDR_W-1:0] r_base  [NUM_CHANNELS];
  logic [FEAT_W:0]   r_count [NUM_CHANNELS];
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_err;
  logic [PipeD-1:0]  r_pipe_vld;
  logic [CHAN_W-1:0] r_pipe_tag [PipeD];
  logic [HV_DIM-1:0] r_fifo_data [FIFO_DEPTH];
  logic [CHAN_W-1:0] r_fifo_chan [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_fifo_cnt;
  logic [CntW-1:0]   r_used;     // FIFO entries plus reads still in the ROM pipeline

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_chan_ok;
  logic [ADDR_W-1:0] w_base;
  logic [FEAT_W:0]   w_count;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_addr;

  // Handshakes; in_ready depends on registered state only
  assign in_ready  = !rst && (r_used < CntW'(FIFO_DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_pipe_vld[PipeD-1];
  assign out_valid = (r_fifo_cnt != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_cim   = out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_chan  = out_valid ? r_fifo_chan[r_rd_ptr] : '0;
  assign rom_addr  = r_rom_addr;
  assign err       = r_err;

  // Table lookup for the requested channel; unknown channels read as zero
  always_comb begin
    w_base    = '0;
    w_count   = '0;
    w_chan_ok = (32'(in_chan) < NUM_CHANNELS);
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (in_chan == CHAN_W'(i)) begin
        w_base  = r_base[i];
        w_count = r_count[i];
      end
    end
  end

`ifdef CIM_CLAMP_EN
  // Offset within the channel, clamped to the last programmed level
  always_comb begin
    w_off = ADDR_W'(in_feature);
    if ({1'b0, in_feature} >= w_count) begin
      w_off = (w_count == '0) ? '0 : ADDR_W'(w_count - 1'b1);
    end
  end
`else
  logic w_unused_count;
  assign w_unused_count = ^w_count;

  // Offset within the channel, no range check
  always_comb begin
    w_off = ADDR_W'(in_feature);
  end
`endif

  // Final address wraps modulo 2^ADDR_W; invalid channels go to address 0
  always_comb begin
    w_addr = w_chan_ok ? (w_base + w_off) : '0;
  end

  // Configuration table writes; out-of-range entries are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        r_base[i]  <= '0;
        r_count[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        if (cfg_chan == CHAN_W'(i)) begin
          r_base[i]  <= cfg_base;
          r_count[i] <= cfg_count;
        end
      end
    end
  end

  // ROM address register, sticky error and the valid/tag pipeline matching ROM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_err      <= 1'b0;
      r_pipe_vld <= '0;
      for (int i = 0; i < int'(PipeD); i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_rom_addr <= w_addr;
        if (!w_chan_ok) begin
          r_err <= 1'b1;
        end
      end
      r_pipe_vld    <= {r_pipe_vld[PipeD-2:0], w_accept};
      r_pipe_tag[0] <= in_chan;
      for (int i = 1; i < int'(PipeD); i++) begin
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  // FIFO pointers, occupancy and credit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_used     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_fifo_cnt <= r_fifo_cnt + CntW'(w_push) - CntW'(w_pop);
      r_used     <= r_used + CntW'(w_accept) - CntW'(w_pop);
    end
  end

  // FIFO storage; contents are masked by out_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= rom_dout;
      r_fifo_chan[r_wr_ptr] <= r_pipe_tag[PipeD-1];
    end
  end

endmodule

// File: tb/tb_cim_fetch_unit.sv
// Scoreboard bench for cim_fetch_unit: the negedge monitor keeps a table/queue model,
// pushes expected reads on accept and pops/compares on every output handshake.
module tb_cim_fetch_unit;

  localparam int HV    = 2000;
  localparam int NCH   = 6;
  localparam int CW    = 3;
  localparam int FW    = 6;
  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_chan;
  logic [FW-1:0] in_feature;
  logic          out_valid;
  logic          out_ready;
  logic [HV-1:0] out_cim;
  logic [CW-1:0] out_chan;
  logic [AW-1:0] rom_addr;
  logic [HV-1:0] rom_dout;
  logic          cfg_we;
  logic [CW-1:0] cfg_chan;
  logic [AW-1:0] cfg_base;
  logic [FW:0]   cfg_count;
  logic          err;

  cim_fetch_unit #(
    .HV_DIM      (HV),
    .NUM_CHANNELS(NCH),
    .CHAN_W      (CW),
    .FEAT_W      (FW),
    .ADDR_W      (AW),
    .ROM_LATENCY (1),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chan   (in_chan),
    .in_feature(in_feature),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cim   (out_cim),
    .out_chan  (out_chan),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .cfg_we    (cfg_we),
    .cfg_chan  (cfg_chan),
    .cfg_base  (cfg_base),
    .cfg_count (cfg_count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a hash of the address, distinct for every address
  function automatic logic [HV-1:0] rom_word(input logic [AW-1:0] a);
    logic [2047:0] t;
    for (int i = 0; i < 64; i++) begin
      t[i*32 +: 32] = ({20'h0, a} * 32'h9E3779B1) ^ (i * 32'h85EBCA6B) ^ {20'h0, a};
    end
    return t[HV-1:0];
  endfunction

  // External synchronous ROM, one cycle latency
  always @(posedge clk) rom_dout <= rom_word(rom_addr);

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] chan;
  } exp_t;

  exp_t          exp_q[$];
  int            m_base[NCH];
  int            m_cnt[NCH];
  logic          m_err;
  logic [AW-1:0] m_rom_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference address rule, straight from the table semantics
  function automatic logic [AW-1:0] model_addr(input int ch, input int f);
    int a;
    if (ch >= NCH) return '0;
    a = m_base[ch] + f;
`ifdef CIM_CLAMP_EN
    if (f >= m_cnt[ch]) a = m_base[ch] + ((m_cnt[ch] == 0) ? 0 : m_cnt[ch] - 1);
`endif
    return AW'(a % (1 << AW));
  endfunction

  // Monitor/scoreboard: compares state seen now, then models the coming edge
  always @(negedge clk) begin
    exp_t e;
    logic [AW-1:0] a;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_rom_addr", rom_addr, 0);
      exp_q.delete();
      m_err      = 1'b0;
      m_rom_addr = '0;
      for (int i = 0; i < NCH; i++) begin
        m_base[i] = 0;
        m_cnt[i]  = 0;
      end
    end else begin
      chk("in_ready", in_ready, (exp_q.size() < DEPTH));
      chk("rom_addr", rom_addr, m_rom_addr);
      chk("err", err, m_err);
      if (out_valid && exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stale_output: out_valid=1 with nothing outstanding, chan %0d", out_chan);
      end else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("out_chan", out_chan, e.chan);
        n_checks++;
        if (out_cim !== rom_word(e.addr)) begin
          n_fail++;
          $display("FAIL out_cim: got low64 %0h expected low64 %0h (addr %0d)",
                   out_cim[63:0], rom_word(e.addr) & 64'hFFFF_FFFF_FFFF_FFFF, e.addr);
        end
      end
      if (in_valid && in_ready) begin
        a = model_addr(int'(in_chan), int'(in_feature));
        exp_q.push_back('{addr: a, chan: in_chan});
        m_rom_addr = a;
        if (int'(in_chan) >= NCH) m_err = 1'b1;
      end
      if (cfg_we && int'(cfg_chan) < NCH) begin
        m_base[int'(cfg_chan)] = int'(cfg_base);
        m_cnt[int'(cfg_chan)]  = int'(cfg_count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int base, input int cnt);
    cfg_we    = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_base  = AW'(base);
    cfg_count = (FW+1)'(cnt);
    step();
    cfg_we = 1'b0;
  endtask

  // Issue one request and hold it until accepted (bounded)
  task automatic req(input int ch, input int f);
    bit ok;
    ok         = 1'b0;
    in_valid   = 1'b1;
    in_chan    = CW'(ch);
    in_feature = FW'(f);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      step();
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: request (%0d,%0d) never accepted", ch, f);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs still pending, expected 0", exp_q.size());
    end
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_feature = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_chan = '0; cfg_base = '0; cfg_count = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("first_cycle_in_ready", in_ready, 1);
    step();

    // Basic lookup and fixed latency
    cfg(0, 0, 21);
    cfg(4, 63, 21);
    req(4, 5);
    chk("t1_rom_addr", rom_addr, 68);
    chk("t1_valid_edge_k", out_valid, 0);
    step();
    chk("t1_valid_edge_k1", out_valid, 0);
    step();
    chk("t1_valid_edge_k2", out_valid, 1);
    chk("t1_out_chan", out_chan, 4);
    drain();

    // Credit limit with a stalled consumer
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_chan    = CW'($urandom_range(0, NCH - 1));
      in_feature = FW'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("t2_accepted", acc, 4);
    chk("t2_in_ready_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("t2_ready_after_pop", in_ready, 1);
    drain();

    // Table write on the accepting edge uses the old base
    cfg(1, 50, 21);
    cfg_we = 1'b1; cfg_chan = 3'd1; cfg_base = 12'd100; cfg_count = 7'd21;
    req(1, 2);
    cfg_we = 1'b0;
    chk("t3_old_base", rom_addr, 52);
    req(1, 2);
    chk("t3_new_base", rom_addr, 102);

    // Invalid channel: address 0, sticky error
    req(7, 0);
    chk("t4_inv_addr", rom_addr, 0);
    chk("t4_err_set", err, 1);
    req(0, 3);
    chk("t4_err_sticky", err, 1);
    chk("t4_valid_addr", rom_addr, 3);

    // Range handling and address wrap
    req(0, 40);
`ifdef CIM_CLAMP_EN
    chk("t5_clamp", rom_addr, 20);
`else
    chk("t5_noclamp", rom_addr, 40);
`endif
    cfg(2, 4090, 21);
    req(2, 10);
    chk("t5_wrap", rom_addr, 4);
    drain();

    // Randomised traffic with random back-pressure and config writes
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_chan    = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(6, 7))
                                               : CW'($urandom_range(0, NCH - 1));
      in_feature = FW'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_chan   = CW'($urandom_range(0, 7));
      cfg_base   = AW'($urandom);
      cfg_count  = (FW+1)'($urandom_range(0, 64));
      step();
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    drain();

    // Reset with reads in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_chan   = 3'd0;
    for (int i = 0; i < 3; i++) begin
      in_feature = FW'(i);
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t6_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (10) step();
    chk("t6_no_stale", out_valid, 0);
    cfg(0, 7, 21);
    req(0, 1);
    chk("t6_after_rst_addr", rom_addr, 8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
